// File: rtl/seg_dec_pkg.sv
// Shared constants and types for the seven-segment display decoder.
// Optional feature macro: SEG_DEC_DP_EN (bit 7 of each bus is a decimal point).
package seg_dec_pkg;

  localparam int unsigned VALUE_W = 7;

  // Segment codes, bit order g..a
  localparam logic [6:0] SEG_0 = 7'h3f;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5b;
  localparam logic [6:0] SEG_3 = 7'h4f;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6d;
  localparam logic [6:0] SEG_6 = 7'h7d;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7f;
  localparam logic [6:0] SEG_9 = 7'h6f;

  // Decoder output for any code that is not an exact digit match
  localparam logic [3:0] BCD_ILLEGAL = 4'hf;

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} dec_state_e;

  // Two-digit BCD to binary value 0..99
  function automatic logic [VALUE_W-1:0] bcd_to_value(input logic [3:0] tens,
                                                      input logic [3:0] units);
    return VALUE_W'(tens) * VALUE_W'(10) + VALUE_W'(units);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one 9-bit segment bus into BCD plus a legal flag.
// Optional feature macro: SEG_DEC_DP_EN (bit 7 becomes a decimal-point flag).
module seg7_to_bcd
  import seg_dec_pkg::*;
(
  input  logic [8:0] seg,
  output logic [3:0] bcd,
`ifdef SEG_DEC_DP_EN
  output logic       dp,
`endif
  output logic       legal
);

  logic spare_ok;

`ifdef SEG_DEC_DP_EN
  assign spare_ok = ~seg[8];
  assign dp       = seg[7];
`else
  assign spare_ok = (seg[8:7] == 2'b00);
`endif

  // Exact-match lookup; anything else maps to the illegal marker
  always_comb begin
    bcd = BCD_ILLEGAL;
    case (seg[6:0])
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: bcd = BCD_ILLEGAL;
    endcase
  end

  assign legal = spare_ok && (bcd != BCD_ILLEGAL);

endmodule

// File: rtl/seg_display_decoder.sv
// Receiver for the two-digit seven-segment bus: glitch filter, BCD decode,
// count-direction tracking and step-period measurement.
// Optional feature macro: SEG_DEC_DP_EN (adds dp_shi/dp_ge decimal-point outputs).
module seg_display_decoder
  import seg_dec_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8:0]          seg_led_1,
  input  logic [8:0]          seg_led_2,
  input  logic                clear,
  output logic [3:0]          bcd_shi,
  output logic [3:0]          bcd_ge,
`ifdef SEG_DEC_DP_EN
  output logic                dp_shi,
  output logic                dp_ge,
`endif
  output logic                value_valid,
  output logic                update,
  output logic                dir,
  output logic                dir_locked,
  output logic                jump,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                illegal
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [17:0]         raw, sample_q, committed_q;
  logic [CNT_W-1:0]    stab_cnt_q;
  logic [3:0]          dec_shi, dec_ge;
  logic                legal_shi, legal_ge;
  logic                stable, commit, bad;
  logic [VALUE_W-1:0]  new_val, prev_val;
  logic                step_up, step_dn, is_step, same_val;
  dec_state_e          state_q, state_d;
  logic                dir_q, dir_d, locked_q, locked_d, seen_q, seen_d;
  logic                jump_d, jump_q, update_q;
  logic                value_valid_q, illegal_q, period_valid_q;
  logic [3:0]          bcd_shi_q, bcd_ge_q;
  logic [PERIOD_W-1:0] period_q, period_cnt_q;
`ifdef SEG_DEC_DP_EN
  logic                dec_dp_shi, dec_dp_ge, dp_shi_q, dp_ge_q;
`endif

  assign raw = {seg_led_1, seg_led_2};

  seg7_to_bcd u_dec_shi (
    .seg   (sample_q[17:9]),
    .bcd   (dec_shi),
`ifdef SEG_DEC_DP_EN
    .dp    (dec_dp_shi),
`endif
    .legal (legal_shi)
  );

  seg7_to_bcd u_dec_ge (
    .seg   (sample_q[8:0]),
    .bcd   (dec_ge),
`ifdef SEG_DEC_DP_EN
    .dp    (dec_dp_ge),
`endif
    .legal (legal_ge)
  );

  assign stable   = (stab_cnt_q == STAB_MAX);
  assign commit   = stable && (sample_q != committed_q) && legal_shi && legal_ge && !clear;
  assign bad      = stable && !(legal_shi && legal_ge);
  assign new_val  = bcd_to_value(dec_shi, dec_ge);
  assign prev_val = bcd_to_value(bcd_shi_q, bcd_ge_q);
  assign step_up  = (new_val == prev_val + VALUE_W'(1));
  assign step_dn  = (new_val + VALUE_W'(1) == prev_val);
  assign is_step  = step_up || step_dn;
  // Only reachable with dp enabled: a dp-only change keeps the same value
  assign same_val = (new_val == prev_val);

  // Stability filter: sample every cycle, count consecutive identical samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q   <= '0;
      stab_cnt_q <= '0;
    end else begin
      sample_q <= raw;
      if (clear || (raw != sample_q)) begin
        stab_cnt_q <= '0;
      end else if (stab_cnt_q != STAB_MAX) begin
        stab_cnt_q <= stab_cnt_q + CNT_W'(1);
      end
    end
  end

  // FSM and direction state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      locked_q <= 1'b0;
      seen_q   <= 1'b0;
      jump_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      locked_q <= locked_d;
      seen_q   <= seen_d;
      jump_q   <= jump_d;
    end
  end

  // Next-state: seen_q marks that the previous commit was a step in direction dir_q
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    locked_d = locked_q;
    seen_d   = seen_q;
    jump_d   = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      seen_d   = 1'b0;
    end else if (commit) begin
      unique case (state_q)
        IDLE: begin
          state_d = TRACK;
          seen_d  = 1'b0;
        end
        TRACK: begin
          if (is_step) begin
            if (seen_q && (dir_q == step_dn)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
            seen_d = 1'b1;
            dir_d  = step_dn;
          end else if (!same_val) begin
            jump_d = 1'b1;
            seen_d = 1'b0;
          end
        end
        LOCKED: begin
          if (is_step) begin
            if (step_dn != dir_q) begin
              state_d  = TRACK;
              dir_d    = step_dn;
              locked_d = 1'b0;
              seen_d   = 1'b1;
            end
          end else if (!same_val) begin
            state_d  = TRACK;
            jump_d   = 1'b1;
            locked_d = 1'b0;
            seen_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Committed value, sticky flags and period measurement; committed_q survives
  // clear so an unchanged pattern is not re-committed afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      committed_q    <= '0;
      bcd_shi_q      <= '0;
      bcd_ge_q       <= '0;
      update_q       <= 1'b0;
      value_valid_q  <= 1'b0;
      illegal_q      <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      period_cnt_q   <= '0;
`ifdef SEG_DEC_DP_EN
      dp_shi_q       <= 1'b0;
      dp_ge_q        <= 1'b0;
`endif
    end else begin
      update_q <= commit;
      if (clear) begin
        value_valid_q  <= 1'b0;
        illegal_q      <= 1'b0;
        period_q       <= '0;
        period_valid_q <= 1'b0;
        period_cnt_q   <= '0;
      end else begin
        if (bad) begin
          illegal_q <= 1'b1;
        end
        if (commit) begin
          committed_q   <= sample_q;
          bcd_shi_q     <= dec_shi;
          bcd_ge_q      <= dec_ge;
          value_valid_q <= 1'b1;
          period_cnt_q  <= PERIOD_W'(1);
`ifdef SEG_DEC_DP_EN
          dp_shi_q      <= dec_dp_shi;
          dp_ge_q       <= dec_dp_ge;
`endif
          if ((state_q != IDLE) && is_step) begin
            period_q       <= period_cnt_q;
            period_valid_q <= 1'b1;
          end
        end else if ((state_q != IDLE) && (period_cnt_q != '1)) begin
          period_cnt_q <= period_cnt_q + PERIOD_W'(1);
        end
      end
    end
  end

  assign bcd_shi      = bcd_shi_q;
  assign bcd_ge       = bcd_ge_q;
  assign value_valid  = value_valid_q;
  assign update       = update_q;
  assign dir          = dir_q;
  assign dir_locked   = locked_q;
  assign jump         = jump_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign illegal      = illegal_q;
`ifdef SEG_DEC_DP_EN
  assign dp_shi       = dp_shi_q;
  assign dp_ge        = dp_ge_q;
`endif

endmodule

// File: tb/tb_seg_display_decoder.sv
// Scoreboard bench for seg_display_decoder: the driver holds patterns for a
// number of cycles and a reference model predicts each commit; a monitor pops
// the prediction on every update pulse.
module tb_seg_display_decoder;

  localparam int STABLE = 16;
  localparam int PW     = 24;
  localparam logic [6:0] CODES [10] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66,
                                        7'h6d, 7'h7d, 7'h07, 7'h7f, 7'h6f};

  logic          clk = 1'b0;
  logic          rst, clear;
  logic [8:0]    seg_led_1, seg_led_2;
  logic [3:0]    bcd_shi, bcd_ge;
  logic          value_valid, update, dir, dir_locked, jump, period_valid, illegal;
  logic [PW-1:0] period;
`ifdef SEG_DEC_DP_EN
  logic          dp_shi, dp_ge;
`endif

  seg_display_decoder #(
    .STABLE_CYCLES (STABLE),
    .PERIOD_W      (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_led_1    (seg_led_1),
    .seg_led_2    (seg_led_2),
    .clear        (clear),
    .bcd_shi      (bcd_shi),
    .bcd_ge       (bcd_ge),
`ifdef SEG_DEC_DP_EN
    .dp_shi       (dp_shi),
    .dp_ge        (dp_ge),
`endif
    .value_valid  (value_valid),
    .update       (update),
    .dir          (dir),
    .dir_locked   (dir_locked),
    .jump         (jump),
    .period       (period),
    .period_valid (period_valid),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    int     edge_no;
    int     shi;
    int     ge;
    bit     dir;
    bit     locked;
    bit     jump;
    longint period;
    bit     pvalid;
    bit     illegal;
    bit     dp_shi;
    bit     dp_ge;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [17:0] m_committed, m_run_pat;
  int          m_val, m_run, m_last, m_run_start;
  bit          m_started, m_dir, m_pvalid, m_illegal, m_run_done;
  longint      m_period;

  function automatic int digit_of(input logic [8:0] b);
    if (b[8]) return -1;
`ifndef SEG_DEC_DP_EN
    if (b[7]) return -1;
`endif
    for (int i = 0; i < 10; i++) if (b[6:0] == CODES[i]) return i;
    return -1;
  endfunction

  function automatic logic [8:0] enc(input int d);
    return {2'b00, CODES[d]};
  endfunction

  task automatic model_reset();
    m_committed = '0; m_run_pat = '0; m_val = 0; m_run = 0; m_last = 0;
    m_run_start = 0; m_started = 0; m_dir = 0; m_pvalid = 0; m_illegal = 0;
    m_run_done = 1; m_period = 0;
    exp_q.delete();
  endtask

  // A pattern has been stable long enough; the DUT acts on it at edge t_edge
  task automatic model_stable(input logic [8:0] t, input logic [8:0] u, input int t_edge);
    int   dt, du, nv;
    bit   jmp, down;
    exp_t e;
    dt = digit_of(t);
    du = digit_of(u);
    if (dt < 0 || du < 0) begin
      m_illegal = 1;
      return;
    end
    if ({t, u} == m_committed) return;
    nv  = dt * 10 + du;
    jmp = 0;
    if (!m_started) begin
      m_started = 1;
      m_run     = 0;
    end else if (nv == m_val + 1 || nv + 1 == m_val) begin
      down = (nv + 1 == m_val);
      if (m_run > 0 && down == m_dir) m_run++;
      else m_run = 1;
      m_dir    = down;
      m_period = t_edge - m_last;
      if (m_period > (64'd1 << PW) - 1) m_period = (64'd1 << PW) - 1;
      m_pvalid = 1;
    end else if (nv != m_val) begin
      jmp   = 1;
      m_run = 0;
    end
    m_last      = t_edge;
    m_committed = {t, u};
    m_val       = nv;
    e.edge_no = t_edge; e.shi = dt; e.ge = du; e.dir = m_dir; e.locked = (m_run >= 2);
    e.jump = jmp; e.period = m_period; e.pvalid = m_pvalid; e.illegal = m_illegal;
    e.dp_shi = t[7]; e.dp_ge = u[7];
    exp_q.push_back(e);
  endtask

  // Drive a pattern for n clock edges; called just after a rising edge
  task automatic hold(input logic [8:0] t, input logic [8:0] u, input int n);
    int run_end;
    seg_led_1 = t;
    seg_led_2 = u;
    if ({t, u} != m_run_pat) begin
      m_run_pat   = {t, u};
      m_run_start = cyc + 1;
      m_run_done  = 0;
    end
    run_end = cyc + n;
    if (!m_run_done && (run_end - m_run_start + 1 >= STABLE)) begin
      m_run_done = 1;
      model_stable(t, u, m_run_start + STABLE);
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hv(input int v, input int n);
    hold(enc(v / 10), enc(v % 10), n);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    m_run_start = cyc + 1;
    m_run_done  = 0;
    m_illegal = 0; m_started = 0; m_run = 0; m_period = 0; m_pvalid = 0;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bcd_shi"}, bcd_shi, 0);
    chk({tag, "_bcd_ge"}, bcd_ge, 0);
    chk({tag, "_value_valid"}, value_valid, 0);
    chk({tag, "_update"}, update, 0);
    chk({tag, "_dir"}, dir, 0);
    chk({tag, "_dir_locked"}, dir_locked, 0);
    chk({tag, "_jump"}, jump, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_period_valid"}, period_valid, 0);
    chk({tag, "_illegal"}, illegal, 0);
`ifdef SEG_DEC_DP_EN
    chk({tag, "_dp_shi"}, dp_shi, 0);
    chk({tag, "_dp_ge"}, dp_ge, 0);
`endif
  endtask

  // Monitor: every update pulse must match the oldest prediction
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (update === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_update", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("commit_edge", cyc, mon_e.edge_no);
          chk("bcd_shi", bcd_shi, mon_e.shi);
          chk("bcd_ge", bcd_ge, mon_e.ge);
          chk("value_valid", value_valid, 1);
          chk("dir", dir, mon_e.dir);
          chk("dir_locked", dir_locked, mon_e.locked);
          chk("jump", jump, mon_e.jump);
          chk("period", period, mon_e.period);
          chk("period_valid", period_valid, mon_e.pvalid);
          chk("illegal", illegal, mon_e.illegal);
`ifdef SEG_DEC_DP_EN
          chk("dp_shi", dp_shi, mon_e.dp_shi);
          chk("dp_ge", dp_ge, mon_e.dp_ge);
`endif
        end
      end else if (jump === 1'b1) begin
        chk("jump_without_update", jump, 0);
      end
    end
  end

  initial begin
    rst = 1'b0; clear = 1'b0; seg_led_1 = '0; seg_led_2 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Count-up run with 1000-cycle spacing, then down run, then reload jump
    hv(0, 1000); hv(1, 1000); hv(2, 1000);
    chk("up_period", period, 1000);
    chk("up_locked", dir_locked, 1);
    chk("up_dir", dir, 0);
    hv(24, 40); hv(23, 40); hv(22, 40);
    chk("down_dir", dir, 1);
    chk("down_locked", dir_locked, 1);
    hv(24, 40);
    chk("reload_unlocked", dir_locked, 0);

    // Glitch rejection, illegal pattern, clear
    hv(5, 40);
    hold(enc(0), enc(8), 5);
    hv(5, 40);
    chk("glitch_bcd_ge", bcd_ge, 5);
    hold(enc(0), 9'h077, 20);
    chk("illegal_set", illegal, 1);
    chk("illegal_bcd_ge", bcd_ge, 5);
    do_clear();
    chk("clear_illegal", illegal, 0);
    chk("clear_value_valid", value_valid, 0);
    chk("clear_period_valid", period_valid, 0);
    chk("clear_bcd_ge", bcd_ge, 5);

    // Digit wraps are unit steps
    hv(19, 40); hv(20, 40); hv(10, 40); hv(9, 40);

    // Bit 7 on the units bus
    hold(enc(0), 9'h086, 30);
`ifdef SEG_DEC_DP_EN
    chk("dp_illegal", illegal, 0);
    chk("dp_bcd_ge", bcd_ge, 1);
    chk("dp_flag", dp_ge, 1);
`else
    chk("bit7_illegal", illegal, 1);
`endif

    // Asynchronous reset in the middle of a stability window
    hv(21, 8);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomised traffic: biased toward steps, with jumps, glitches and bad codes
    for (int k = 0; k < 160; k++) begin
      int         r, v, n;
      logic [8:0] t, u;
      r = $urandom_range(0, 19);
      v = m_val;
      if (r < 8) v = (v == 99) ? 98 : v + 1;
      else if (r < 12) v = (v == 0) ? 1 : v - 1;
      else v = $urandom_range(0, 99);
      t = enc(v / 10);
      u = enc(v % 10);
      if (r == 19) begin
        case ($urandom_range(0, 2))
          0:       u = 9'h077;
          1:       u = 9'h100 | enc(3);
          default: u = 9'h080 | enc(5);
        endcase
      end
`ifdef SEG_DEC_DP_EN
      if ($urandom_range(0, 5) == 0) t[7] = 1'b1;
`endif
      n = (r == 18) ? $urandom_range(1, 15) : $urandom_range(14, 50);
      hold(t, u, n);
      if (k == 80) begin
        do_clear();
        chk("rand_clear_illegal", illegal, 0);
      end
    end

    hold(seg_led_1, seg_led_2, 40);
    chk("pending_commits", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
